// File: rtl/rr_mux_arbiter_pkg.sv
// Shared encodings and helpers for the two-requester round-robin mux arbiter.
// The state encoding doubles as the grant vector, so RTL and bench agree on both.
package rr_mux_arbiter_pkg;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_OWN0 = S_OWN0,
    ST_OWN1 = S_OWN1
  } state_e;

  // Hold counter must represent 0..HOLD_MAX without wrapping.
  function automatic int cnt_w(input int hold_max);
    return $clog2(hold_max + 1);
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux2to1.sv
// One-bit 2:1 mux lane; the arbiter instantiates one per data bit.
module rr_mux_arbiter_mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter owning a shared 2:1 mux, with a bounded
// hold time per grant and a one-cycle timeout pulse on forced release.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        done,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              address,
  output logic [DATA_W-1:0] dataout,
  output logic              valid,
  output logic              timeout
);

  localparam int              CNT_W   = cnt_w(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              addr_q, addr_d;
  logic              tmo_q, tmo_d;

  logic              own, oth, lim, rel, pick;
  logic [DATA_W-1:0] mux_y;

  assign own = (state_q == ST_OWN1);
  assign oth = ~own;
  assign lim = (cnt_q == CNT_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    tmo_d   = 1'b0;
    rel     = 1'b0;
    pick    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester not served last wins.
          pick    = (req == 2'b11) ? ~last_q : req[1];
          state_d = pick ? ST_OWN1 : ST_OWN0;
          addr_d  = pick;
          cnt_d   = '0;
        end
      end
      ST_OWN0, ST_OWN1: begin
        rel = done[own] | ~req[own] | lim;
        if (rel) begin
          last_d = own;
          // Only a release caused purely by the counter counts as a timeout.
          tmo_d  = lim & ~done[own] & req[own];
          if (req[oth]) begin
            state_d = oth ? ST_OWN1 : ST_OWN0;
            addr_d  = oth;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      addr_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt     = 2'(state_q);
  assign valid   = (state_q != ST_IDLE);
  assign address = addr_q;
  assign timeout = tmo_q;

  for (genvar i = 0; i < DATA_W; i++) begin : g_lane
    rr_mux_arbiter_mux2to1 u_mux (
      .a   (data0[i]),
      .b   (data1[i]),
      .sel (addr_q),
      .y   (mux_y[i])
    );
  end

  assign dataout = valid ? mux_y : '0;

endmodule
